// File: rtl/div_share_pkg.sv
// Shared types for the divider-sharing controller: FSM states and response
// error codes returned to requesters.
package div_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DZ  = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found when
// scanning upward from ptr_i (wrapping) receives a one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_id_o
);

    int   idx;
    logic found;

    // Scan from the pointer, wrap once, stop at the first requester found
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one radix-2 divider between NUM_REQ requesters. One transaction is
// in flight at a time: accept (round-robin), issue, wait with timeout,
// respond. A zero divisor is answered locally without touching the divider.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_sign,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic [1:0]               rsp_err,
    output logic                     div_sign,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    output logic                     div_opn_valid,
    input  logic                     div_res_valid,
    input  logic [2*WIDTH-1:0]       div_result
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TMO_LIM = TW'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       gnt_id_q, gnt_id_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [1:0]           rsp_err_q, rsp_err_d;
    logic                 div_opn_valid_q, div_opn_valid_d;
    logic                 div_sign_q, div_sign_d;
    logic [WIDTH-1:0]     div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]     div_divisor_q, div_divisor_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]       arb_id;
    logic                 accept;
    logic [WIDTH-1:0]     sel_dividend;
    logic [WIDTH-1:0]     sel_divisor;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id)
    );

    // Grant is only offered while idle; held low during reset as well
    always_comb begin
        req_ready = (rst_n && (state_q == ST_IDLE)) ? arb_gnt : '0;
    end

    assign accept       = |(req_valid & req_ready);
    assign sel_dividend = req_dividend[arb_id*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[arb_id*WIDTH +: WIDTH];

    // Next-state logic for the transaction FSM and all registered outputs
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_id_d        = gnt_id_q;
        tmo_cnt_d       = tmo_cnt_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_result_d    = rsp_result_q;
        rsp_err_d       = rsp_err_q;
        div_opn_valid_d = 1'b0;
        div_sign_d      = div_sign_q;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    gnt_id_d       = arb_id;
                    rr_ptr_d       = (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
                    div_sign_d     = req_sign[arb_id];
                    div_dividend_d = sel_dividend;
                    div_divisor_d  = sel_divisor;
                    if (sel_divisor == '0) begin
                        // Divide-by-zero answered immediately, divider untouched
                        state_d      = ST_RESP;
                        rsp_valid_d  = arb_gnt;
                        rsp_result_d = {sel_dividend, {WIDTH{1'b1}}};
                        rsp_err_d    = ERR_DZ;
                    end else begin
                        state_d         = ST_ISSUE;
                        div_opn_valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = '0;
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A result arriving on the timeout cycle still counts as normal
                if (div_res_valid) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = ONE_HOT0 << gnt_id_q;
                    rsp_result_d = div_result;
                    rsp_err_d    = ERR_OK;
                end else if (tmo_cnt_d == TMO_LIM) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = ONE_HOT0 << gnt_id_q;
                    rsp_result_d = '0;
                    rsp_err_d    = ERR_TMO;
                end
            end
            ST_RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            gnt_id_q        <= '0;
            tmo_cnt_q       <= '0;
            rsp_valid_q     <= '0;
            rsp_result_q    <= '0;
            rsp_err_q       <= ERR_OK;
            div_opn_valid_q <= 1'b0;
            div_sign_q      <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_id_q        <= gnt_id_d;
            tmo_cnt_q       <= tmo_cnt_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_result_q    <= rsp_result_d;
            rsp_err_q       <= rsp_err_d;
            div_opn_valid_q <= div_opn_valid_d;
            div_sign_q      <= div_sign_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_err       = rsp_err_q;
    assign div_opn_valid = div_opn_valid_q;
    assign div_sign      = div_sign_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Testbench for div_share_ctrl: directed scenarios followed by randomized
// transactions, each checked against a transaction-level reference model.
module tb_div_share_ctrl;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 63;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_dividend, req_divisor;
    logic [2*W-1:0] rsp_result, div_result;
    logic [1:0]     rsp_err;
    logic           div_sign, div_opn_valid, div_res_valid;
    logic [W-1:0]   div_dividend, div_divisor;

    int n_chk = 0;
    int n_fail = 0;
    int div_lat = 1;     // divider latency in cycles after the issue pulse; 0 = never answers
    int n_pulse = 0;
    int stray_req = 0;
    int stray_seen = 0;
    int model_ptr = 0;
    logic [W-1:0] dm_a, dm_b;
    logic         dm_s;

    always #5 clk = ~clk;

    div_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign      (req_sign),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_err       (rsp_err),
        .div_sign      (div_sign),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_opn_valid (div_opn_valid),
        .div_res_valid (div_res_valid),
        .div_result    (div_result)
    );

    function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b, input logic s);
        int q, r;
        if (b == 8'd0) return 16'hBAD0;
        if (s) begin
            q = int'($signed(a)) / int'($signed(b));
            r = int'($signed(a)) % int'($signed(b));
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        return {r[7:0], q[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        req_sign[i]            = s;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_result"}, rsp_result, 0);
        chk({pfx, "_rsp_err"}, rsp_err, 0);
        chk({pfx, "_opn_valid"}, div_opn_valid, 0);
        chk({pfx, "_div_sign"}, div_sign, 0);
        chk({pfx, "_div_dividend"}, div_dividend, 0);
        chk({pfx, "_div_divisor"}, div_divisor, 0);
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    // Divider stand-in: observes the issue pulse mid-cycle, answers div_lat cycles later
    initial begin : divider_model
        div_res_valid = 1'b0;
        div_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && div_opn_valid === 1'b1) begin
                dm_a = div_dividend;
                dm_b = div_divisor;
                dm_s = div_sign;
                n_pulse++;
                if (div_lat > 0) begin
                    repeat (div_lat) @(posedge clk);
                    #1;
                    div_res_valid = 1'b1;
                    div_result = ref_div(dm_a, dm_b, dm_s);
                    @(posedge clk);
                    #1;
                    div_res_valid = 1'b0;
                end
            end else if (stray_req != stray_seen) begin
                stray_seen++;
                div_res_valid = 1'b1;
                div_result = 16'hBEEF;
                @(posedge clk);
                #1;
                div_res_valid = 1'b0;
            end
        end
    end

    // One full transaction from the currently driven req_valid pattern
    task automatic run_txn(input int bp, input bit keep);
        int g, k, p0, exp_lat;
        logic [15:0] exp_res;
        logic [1:0]  exp_err;
        logic [7:0]  a, b;
        logic        s;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (model_ptr + i) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        if (g < 0) return;
        #1;
        chk("grant", req_ready, 32'(1) << g);
        a = req_dividend[g*W +: W];
        b = req_divisor[g*W +: W];
        s = req_sign[g];
        if (b == 8'd0) begin
            exp_res = {a, 8'hFF}; exp_err = 2'b01; exp_lat = 1;
        end else if (div_lat > 0 && div_lat <= TMO) begin
            exp_res = ref_div(a, b, s); exp_err = 2'b00; exp_lat = div_lat + 2;
        end else begin
            exp_res = 16'h0000; exp_err = 2'b10; exp_lat = TMO + 2;
        end
        p0 = n_pulse;
        tick();
        if (!keep) req_valid[g] = 1'b0;
        model_ptr = (g + 1) % N;
        k = 1;
        while (rsp_valid == '0 && k < 200) begin
            chk("busy_req_ready", req_ready, 0);
            tick();
            k++;
        end
        chk("latency", k, exp_lat);
        chk("rsp_valid", rsp_valid, 32'(1) << g);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, exp_err);
        chk("opn_pulses", n_pulse - p0, (b == 8'd0) ? 0 : 1);
        for (int c = 0; c < bp; c++) begin
            rsp_ready = N'($urandom) & ~(N'(1) << g);
            tick();
            chk("bp_rsp_valid", rsp_valid, 32'(1) << g);
            chk("bp_rsp_result", rsp_result, exp_res);
            chk("bp_rsp_err", rsp_err, exp_err);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = N'(1) << g;
        tick();
        rsp_ready = '0;
        chk("rsp_release", rsp_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int order[5];
        order = '{0, 1, 2, 3, 0};
        req_valid = '0; rsp_ready = '0; req_sign = '0;
        req_dividend = '0; req_divisor = '0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Single requester 1: 100 / 7 -> {2,14} after L=9
        set_op(1, 8'd100, 8'd7, 1'b0);
        div_lat = 9;
        req_valid = 4'b0010;
        run_txn(0, 1'b0);

        // All requesters continuously after reset
        apply_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom_range(1, 255)), 1'($urandom));
        div_lat = 3;
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("rr_order", req_ready, 32'(1) << order[t]);
            run_txn(0, 1'b1);
        end
        req_valid = '0;

        // Divide-by-zero from requester 2
        set_op(2, 8'h5A, 8'h00, 1'b0);
        req_valid = 4'b0100;
        run_txn(0, 1'b0);

        // Timeout, then a stray result in IDLE
        set_op(3, 8'd77, 8'd5, 1'b0);
        div_lat = 0;
        req_valid = 4'b1000;
        run_txn(0, 1'b0);
        stray_req++;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("stray_rsp_valid", rsp_valid, 0);
            chk("stray_rsp_result", rsp_result, 0);
        end

        // Result on the timeout cycle wins; one cycle later loses
        set_op(0, 8'd200, 8'd9, 1'b0);
        div_lat = TMO;
        req_valid = 4'b0001;
        run_txn(0, 1'b0);
        set_op(1, 8'hF0, 8'h07, 1'b1);
        div_lat = TMO + 1;
        req_valid = 4'b0010;
        run_txn(0, 1'b0);
        tick();
        tick();

        // Long back-pressure on requester 0
        set_op(0, 8'd250, 8'd3, 1'b0);
        div_lat = 5;
        req_valid = 4'b0001;
        run_txn(20, 1'b1);
        req_valid = '0;

        // Reset while waiting on the divider
        set_op(2, 8'd40, 8'd6, 1'b0);
        div_lat = 0;
        req_valid = 4'b0100;
        #1;
        chk("pre_rst_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("wait_rst");
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_rsp_valid", rsp_valid, 0);
        end
        set_op(2, 8'd91, 8'd4, 1'b0);
        set_op(3, 8'd19, 8'd2, 1'b0);
        div_lat = 4;
        req_valid = 4'b1100;
        #1;
        chk("post_rst_grant", req_ready, 4'b0100);
        run_txn(0, 1'b0);
        req_valid = '0;

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, 8'($urandom), ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                       1'($urandom));
            end
            div_lat = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 12));
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            run_txn(int'($urandom_range(0, 3)), 1'($urandom));
        end
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
